// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard/stall scheduler:
//   hz_state_e   - scheduler FSM state (RUN / PEND / FLUSH), also exported on
//                  the debug port state_o
//   PC_*         - encodings of the fetch PC-select output
//   hz_ctrl_t    - bundle of per-stage stall/bubble controls plus pc_sel
//   src_match()  - "destination register feeds one of the decode sources"
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    FLUSH = 2'd2
  } hz_state_e;

  localparam logic [1:0] PC_PRED = 2'b00;  // sequential / predicted PC
  localparam logic [1:0] PC_JUMP = 2'b01;  // decode-resolved jump target
  localparam logic [1:0] PC_EXC  = 2'b10;  // exception vector

  // Flush counter width; covers FLUSH_CYCLES in 1..7.
  localparam int CNT_W = 3;

  typedef struct packed {
    logic       f_stall;
    logic       d_stall;
    logic       e_stall;
    logic       m_stall;
    logic       d_bubble;
    logic       e_bubble;
    logic       m_bubble;
    logic       w_bubble;
    logic [1:0] pc_sel;
  } hz_ctrl_t;

  // $zero is hard-wired, so a write to it can never create a dependency.
  function automatic logic src_match(input logic [4:0] dst,
                                     input logic [4:0] src1,
                                     input logic [4:0] src2);
    return (dst != 5'd0) && ((dst == src1) || (dst == src2));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard scheduler.
//   Datapath -> scheduler : decode sources, E/M destinations and load flags,
//                           HI/LO use, mul/div busy, decode jump, cache busy,
//                           exception pulse from M.
//   Scheduler -> datapath : F/D/E/M stalls, D/E/M/W bubbles, fetch pc_sel.
// Modports:
//   master - the pipeline datapath (drives hazard sources, consumes controls)
//   slave  - the scheduler (pipe_hazard_ctrl)
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;

  logic [4:0] d_src1;
  logic [4:0] d_src2;
  logic [4:0] e_dst;
  logic [4:0] m_dst;
  logic       e_isLoad;
  logic       m_isLoad;
  logic       d_useHiLo;
  logic       md_busy;
  logic       d_jump;
  logic       i_busy;
  logic       d_busy;
  logic       exception;

  logic       F_stall;
  logic       D_stall;
  logic       E_stall;
  logic       M_stall;
  logic       D_bubble;
  logic       E_bubble;
  logic       M_bubble;
  logic       W_bubble;
  logic [1:0] pc_sel;

  modport master (
    output d_src1, d_src2, e_dst, m_dst, e_isLoad, m_isLoad, d_useHiLo,
           md_busy, d_jump, i_busy, d_busy, exception,
    input  F_stall, D_stall, E_stall, M_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, pc_sel
  );

  modport slave (
    input  d_src1, d_src2, e_dst, m_dst, e_isLoad, m_isLoad, d_useHiLo,
           md_busy, d_jump, i_busy, d_busy, exception,
    output F_stall, D_stall, E_stall, M_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, pc_sel
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Purely combinational decode-stage data hazard detection. Also used by the
// issue checker, so it carries no state and no clock.
//   d_src1_i/d_src2_i  decode source registers
//   e_dst_i/m_dst_i    destination registers in E and M
//   e_is_load_i/m_is_load_i  E/M instruction is a load
//   d_use_hilo_i       decode instruction reads HI/LO
//   md_busy_i          multiplier/divider still computing
//   lu_o               load-use hazard
//   hl_o               HI/LO hazard
// Parameter M_LOAD_HAZARD=1 also treats a load in M as a load-use source
// (dcache returns data late in that configuration).
// ---------------------------------------------------------------------------
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter bit M_LOAD_HAZARD = 1'b0
) (
  input  logic [4:0] d_src1_i,
  input  logic [4:0] d_src2_i,
  input  logic [4:0] e_dst_i,
  input  logic [4:0] m_dst_i,
  input  logic       e_is_load_i,
  input  logic       m_is_load_i,
  input  logic       d_use_hilo_i,
  input  logic       md_busy_i,
  output logic       lu_o,
  output logic       hl_o
);

  logic e_lu;
  logic m_lu;

  assign e_lu = e_is_load_i && src_match(e_dst_i, d_src1_i, d_src2_i);
  assign m_lu = M_LOAD_HAZARD && m_is_load_i
                && src_match(m_dst_i, d_src1_i, d_src2_i);

  assign lu_o = e_lu || m_lu;
  assign hl_o = d_use_hilo_i && md_busy_i;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/bubble scheduler for the 5-stage MIPS pipeline.
// Ports:
//   clk, resetn  clock, asynchronous active-low reset
//   hz           pipe_hazard_ctrl_if.slave: hazard sources in, per-stage
//                stall/bubble controls and fetch pc_sel out
//   state_o      scheduler state (debug): 0 RUN, 1 PEND, 2 FLUSH
//   perf_lu, perf_mem, perf_flush  (only with HAZARD_PERF_EN defined)
//                32-bit wrap-around counts of load-use/HI-LO stall cycles,
//                memory-wait cycles and FLUSH cycles
// Parameters:
//   FLUSH_CYCLES   cycles FLUSH holds D/E/M bubbles (1..7)
//   M_LOAD_HAZARD  1 = a load in M also causes a load-use stall
// Controls are combinational from the registered state and current inputs.
// An exception raised while a cache is waiting is parked in PEND and flushed
// once memory is idle, so the redirect never races an outstanding access.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES  = 1,
  parameter bit          M_LOAD_HAZARD = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  pipe_hazard_ctrl_if.slave     hz,
  output logic [1:0]            state_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_lu,
  output logic [31:0]           perf_mem,
  output logic [31:0]           perf_flush
`endif
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  hz_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_wait;
  logic             lu;
  logic             hl;
  hz_ctrl_t         ctrl;

  hazard_detect #(
    .M_LOAD_HAZARD(M_LOAD_HAZARD)
  ) u_hazard_detect (
    .d_src1_i    (hz.d_src1),
    .d_src2_i    (hz.d_src2),
    .e_dst_i     (hz.e_dst),
    .m_dst_i     (hz.m_dst),
    .e_is_load_i (hz.e_isLoad),
    .m_is_load_i (hz.m_isLoad),
    .d_use_hilo_i(hz.d_useHiLo),
    .md_busy_i   (hz.md_busy),
    .lu_o        (lu),
    .hl_o        (hl)
  );

  assign mem_wait = hz.i_busy || hz.d_busy;

  // NOTE: the reset branch sits in the sensitivity list with negedge resetn,
  // so state clears immediately, not at the next clock edge.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.exception) begin
            if (mem_wait) begin
              state_q <= PEND;
            end else begin
              state_q <= FLUSH;
              cnt_q   <= CNT_INIT;
            end
          end
        end
        PEND: begin
          // Exceptions arriving here are dropped: one is already queued.
          if (!mem_wait) begin
            state_q <= FLUSH;
            cnt_q   <= CNT_INIT;
          end
        end
        FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= RUN;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= RUN;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Priority mux. Every stage gets either a stall or a bubble, never both.
  // NOTE: ctrl gets a full default before the if-chain so no path leaves a
  // field unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl        = '0;
    ctrl.pc_sel = PC_PRED;
    if (!resetn) begin
      // Held in reset: drain everything, hold nothing.
      ctrl.d_bubble = 1'b1;
      ctrl.e_bubble = 1'b1;
      ctrl.m_bubble = 1'b1;
      ctrl.w_bubble = 1'b1;
    end else if (state_q == FLUSH) begin
      // W keeps the excepting instruction's predecessors; only redirect once.
      ctrl.d_bubble = 1'b1;
      ctrl.e_bubble = 1'b1;
      ctrl.m_bubble = 1'b1;
      ctrl.pc_sel   = (cnt_q == CNT_INIT) ? PC_EXC : PC_PRED;
    end else if (mem_wait) begin
      // Freeze the whole front of the pipe; W must not retire M twice.
      ctrl.f_stall  = 1'b1;
      ctrl.d_stall  = 1'b1;
      ctrl.e_stall  = 1'b1;
      ctrl.m_stall  = 1'b1;
      ctrl.w_bubble = 1'b1;
    end else if ((state_q == RUN) && hz.exception) begin
      // Memory idle: redirect in the same cycle the exception commits.
      ctrl.d_bubble = 1'b1;
      ctrl.e_bubble = 1'b1;
      ctrl.m_bubble = 1'b1;
      ctrl.pc_sel   = PC_EXC;
    end else if (lu || hl) begin
      // The stalled decode instruction re-presents its jump next cycle.
      ctrl.f_stall  = 1'b1;
      ctrl.d_stall  = 1'b1;
      ctrl.e_bubble = 1'b1;
    end else if (hz.d_jump) begin
      // Delay slot is already in F, so no bubble is needed.
      ctrl.pc_sel = PC_JUMP;
    end
  end

  assign hz.F_stall  = ctrl.f_stall;
  assign hz.D_stall  = ctrl.d_stall;
  assign hz.E_stall  = ctrl.e_stall;
  assign hz.M_stall  = ctrl.m_stall;
  assign hz.D_bubble = ctrl.d_bubble;
  assign hz.E_bubble = ctrl.e_bubble;
  assign hz.M_bubble = ctrl.m_bubble;
  assign hz.W_bubble = ctrl.w_bubble;
  assign hz.pc_sel   = ctrl.pc_sel;
  assign state_o     = state_q;

`ifdef HAZARD_PERF_EN
  logic        rule_mem;
  logic        rule_lu;
  logic [31:0] perf_lu_q;
  logic [31:0] perf_mem_q;
  logic [31:0] perf_flush_q;

  assign rule_mem = (state_q != FLUSH) && mem_wait;
  assign rule_lu  = (state_q != FLUSH) && !mem_wait
                    && !((state_q == RUN) && hz.exception) && (lu || hl);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lu_q    <= '0;
      perf_mem_q   <= '0;
      perf_flush_q <= '0;
    end else begin
      if (rule_lu)           perf_lu_q    <= perf_lu_q + 32'd1;
      if (rule_mem)          perf_mem_q   <= perf_mem_q + 32'd1;
      if (state_q == FLUSH)  perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_lu    = perf_lu_q;
  assign perf_mem   = perf_mem_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule
